// File: rtl/tt_um_dev_gate_array_pkg.sv
// ---------------------------------------------------------------------------
// tt_dev_gate_pkg
// Shared definitions for the gate-array tile:
//   - fn_e       : 3-bit gate function codes (reset function is NAND)
//   - gate_fn()  : pure two-input gate evaluation for a given code
//   - UIO_*      : bit positions of the fields carried on uio_in / uio_out
// ---------------------------------------------------------------------------
package tt_dev_gate_pkg;

    typedef enum logic [2:0] {
        FN_NAND = 3'd0,
        FN_AND  = 3'd1,
        FN_NOR  = 3'd2,
        FN_OR   = 3'd3,
        FN_XOR  = 3'd4,
        FN_XNOR = 3'd5,
        FN_PASS = 3'd6,   // Y = A
        FN_NOTA = 3'd7    // Y = ~A
    } fn_e;

    // uio_in field positions
    localparam int UIO_CODE_LSB = 0;
    localparam int UIO_CODE_W   = 3;
    localparam int UIO_LOAD_BIT = 3;
    localparam int UIO_SEL_LSB  = 4;
    localparam int UIO_SEL_W    = 2;
    // Only uio_in[5:0] carries meaning and is synchronised.
    localparam int UIO_SYNC_W   = 6;

    // uio_out field positions
    localparam int UIO_ACK_BIT  = 6;
    localparam int UIO_SAT_BIT  = 7;

    // uio[7:6] are outputs, uio[5:0] are inputs.
    localparam logic [7:0] UIO_OE_VALUE = 8'b1100_0000;

    function automatic logic gate_fn(input logic [2:0] code, input logic a, input logic b);
        logic y;
        case (code)
            FN_NAND: y = ~(a & b);
            FN_AND:  y = a & b;
            FN_NOR:  y = ~(a | b);
            FN_OR:   y = a | b;
            FN_XOR:  y = a ^ b;
            FN_XNOR: y = ~(a ^ b);
            FN_PASS: y = a;
            FN_NOTA: y = ~a;
            default: y = ~(a & b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/tt_um_dev_gate_array_if.sv
// ---------------------------------------------------------------------------
// tt_um_dev_gate_array_if
// Bundle of the Tiny Tapeout user-module pins (everything except clk/rst_n).
//   master : the environment driving the tile (ena, ui_in, uio_in out;
//            uo_out, uio_out, uio_oe in)
//   slave  : the tile side of the same pins
// ---------------------------------------------------------------------------
interface tt_um_dev_gate_array_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_dev_gate_array_channel.sv
// ---------------------------------------------------------------------------
// dev_gate_channel
// One gate channel: registered gate output plus a saturating counter of
// output toggles.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   mode        : current gate function
//   a, b        : synchronised gate inputs
//   clr         : clear the counter (wins over an increment on the same edge)
//   suppress    : do not count on this edge (first edge after a mode change)
//   y           : registered gate result
//   cnt         : toggle count, saturates at all-ones
//   sat         : cnt is saturated
// ---------------------------------------------------------------------------
module dev_gate_channel
    import tt_dev_gate_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  fn_e              mode,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    input  logic             suppress,
    output logic             y,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic y_next;
    assign y_next = gate_fn(mode, a, b);

    // Y resets to 1: the reset mode is NAND and the reset inputs are 0, so
    // the first evaluation after release produces no spurious toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y   <= 1'b1;
            cnt <= '0;
        end else begin
            y <= y_next;
            if (clr) begin
                cnt <= '0;
            end else if (!suppress && (y_next != y) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/tt_um_dev_gate_array.sv
// ---------------------------------------------------------------------------
// tt_um_dev_gate_array
// Array of up to four two-input gate channels sharing one runtime-selectable
// function, with synchronised inputs, registered outputs and per-channel
// saturating toggle counters.
// Ports (standard Tiny Tapeout user pinout):
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   ena      : power-good, ignored
//   ui_in    : channel i uses A = ui_in[i], B = ui_in[i+4]
//   uio_in   : [2:0] function code, [3] load strobe, [5:4] readout select
//   uo_out   : [3:0] gate results, [7:4] selected toggle count
//   uio_out  : [7] selected counter saturated, [6] load_ack, [5:0] 0
//   uio_oe   : constant 8'b1100_0000
// ---------------------------------------------------------------------------
module tt_um_dev_gate_array
    import tt_dev_gate_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int SYNC_W = 8 + UIO_SYNC_W;

    // ---- input synchronisers ------------------------------------------------
    logic [SYNC_W-1:0]                  sync_raw;
    logic [SYNC_STAGES-1:0][SYNC_W-1:0] sync_q;
    logic [SYNC_W-1:0]                  synced;

    assign sync_raw = {uio_in[UIO_SYNC_W-1:0], ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= sync_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    logic [3:0]            a_s;
    logic [3:0]            b_s;
    logic [UIO_SYNC_W-1:0] uio_s;
    logic [2:0]            code_s;
    logic                  strobe_s;
    logic [1:0]            sel_s;

    assign a_s      = synced[3:0];
    assign b_s      = synced[7:4];
    assign uio_s    = synced[SYNC_W-1:8];
    assign code_s   = uio_s[UIO_CODE_LSB +: UIO_CODE_W];
    assign strobe_s = uio_s[UIO_LOAD_BIT];
    assign sel_s    = uio_s[UIO_SEL_LSB +: UIO_SEL_W];

    // ---- strobe edge detect, mode register, load_ack, suppress --------------
    logic strobe_q;
    logic load;
    logic load_ack;
    logic suppress;
    fn_e  mode;

    // A held-high strobe produces exactly one load.
    assign load = strobe_s & ~strobe_q;

    // suppress marks the first edge evaluated with the new function so the
    // switch itself is never counted as a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_q <= 1'b0;
            load_ack <= 1'b0;
            suppress <= 1'b0;
            mode     <= FN_NAND;
        end else begin
            strobe_q <= strobe_s;
            load_ack <= load;
            suppress <= load;
            if (load) begin
                mode <= fn_e'(code_s);
            end
        end
    end

    // ---- gate channels ------------------------------------------------------
    logic [3:0]            y_all;
    logic [3:0][CNT_W-1:0] cnt_all;
    logic [3:0]            sat_all;

    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < CHANNELS) begin : g_on
            dev_gate_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .mode     (mode),
                .a        (a_s[i]),
                .b        (b_s[i]),
                .clr      (load),
                .suppress (suppress),
                .y        (y_all[i]),
                .cnt      (cnt_all[i]),
                .sat      (sat_all[i])
            );
        end else begin : g_off
            assign y_all[i]   = 1'b0;
            assign cnt_all[i] = '0;
            assign sat_all[i] = 1'b0;
        end
    end

    // ---- readout mux and outputs -------------------------------------------
    logic [3:0] cnt_sel;
    logic       sat_sel;

    // A select pointing past the built channels reads as zero.
    always_comb begin
        cnt_sel = '0;
        sat_sel = 1'b0;
        if (int'(sel_s) < CHANNELS) begin
            cnt_sel = 4'(cnt_all[sel_s]);
            sat_sel = sat_all[sel_s];
        end
    end

    assign uo_out = {cnt_sel, y_all};

    always_comb begin
        uio_out              = '0;
        uio_out[UIO_SAT_BIT] = sat_sel;
        uio_out[UIO_ACK_BIT] = load_ack;
    end

    assign uio_oe = UIO_OE_VALUE;

    // ena and uio_in[7:6] carry no function; inputs of unbuilt channels are
    // synchronised but never used.
    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in[7:6], a_s, b_s};

endmodule

// File: tb/tb_tt_um_dev_gate_array.sv
module tb_tt_um_dev_gate_array;
    import tt_dev_gate_pkg::*;

    localparam int SS   = 2;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    tt_um_dev_gate_array_if bus4 ();
    tt_um_dev_gate_array_if bus2 ();

    assign bus2.ena    = bus4.ena;
    assign bus2.ui_in  = bus4.ui_in;
    assign bus2.uio_in = bus4.uio_in;

    tt_um_dev_gate_array #(.CHANNELS(4), .CNT_W(4), .SYNC_STAGES(SS)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus4.ena),
        .ui_in   (bus4.ui_in),
        .uo_out  (bus4.uo_out),
        .uio_in  (bus4.uio_in),
        .uio_out (bus4.uio_out),
        .uio_oe  (bus4.uio_oe)
    );

    tt_um_dev_gate_array #(.CHANNELS(2), .CNT_W(4), .SYNC_STAGES(SS)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (bus2.ena),
        .ui_in   (bus2.ui_in),
        .uo_out  (bus2.uo_out),
        .uio_in  (bus2.uio_in),
        .uio_out (bus2.uio_out),
        .uio_oe  (bus2.uio_oe)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: truth tables indexed by {a,b}, input history of
    // pin samples taken at each rising edge (index 0 = newest).
    logic [3:0]  truth_tab [8];
    logic [13:0] hist [SS+2];
    logic [3:0]  m_y;
    int          m_cnt [4];
    logic [2:0]  m_mode;
    logic        m_supp;
    logic        m_ack;
    logic [1:0]  m_sel;

    function automatic logic truth(input logic [2:0] code, input logic a, input logic b);
        logic [3:0] row;
        row = truth_tab[code];
        return row[{a, b}];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < SS + 2; i++) hist[i] = '0;
        m_y    = 4'hF;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_mode = 3'd0;
        m_supp = 1'b0;
        m_ack  = 1'b0;
        m_sel  = 2'd0;
    endfunction

    function automatic void model_edge();
        logic [13:0] cur;
        logic [13:0] prv;
        logic        ld;
        logic        yn;
        for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {bus4.uio_in[5:0], bus4.ui_in};
        cur = hist[SS];
        prv = hist[SS+1];
        ld  = cur[11] & ~prv[11];
        for (int c = 0; c < 4; c++) begin
            yn = truth(m_mode, cur[c], cur[c+4]);
            if (ld) m_cnt[c] = 0;
            else if (!m_supp && (yn != m_y[c]) && (m_cnt[c] < CMAX)) m_cnt[c] = m_cnt[c] + 1;
            m_y[c] = yn;
        end
        m_ack  = ld;
        m_supp = ld;
        if (ld) m_mode = cur[10:8];
        m_sel = hist[SS-1][13:12];
    endfunction

    function automatic logic [7:0] exp_uo(input int chans);
        logic [3:0] yv;
        logic [3:0] cv;
        yv = '0;
        cv = '0;
        for (int i = 0; i < chans; i++) yv[i] = m_y[i];
        if (int'(m_sel) < chans) cv = 4'(m_cnt[m_sel]);
        return {cv, yv};
    endfunction

    function automatic logic [7:0] exp_uio(input int chans);
        logic s;
        s = (int'(m_sel) < chans) && (m_cnt[m_sel] == CMAX);
        return {s, m_ack, 6'b0};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("uo4",  bus4.uo_out,  exp_uo(4));
        check("uio4", bus4.uio_out, exp_uio(4));
        check("oe4",  bus4.uio_oe,  8'hC0);
        check("uo2",  bus2.uo_out,  exp_uo(2));
        check("uio2", bus2.uio_out, exp_uio(2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uo4"},  bus4.uo_out,  8'h0F);
        check({tag, "_uio4"}, bus4.uio_out, 8'h00);
        check({tag, "_oe4"},  bus4.uio_oe,  8'hC0);
        check({tag, "_uo2"},  bus2.uo_out,  8'h03);
        check({tag, "_uio2"}, bus2.uio_out, 8'h00);
    endtask

    initial begin
        int         acks;
        logic [7:0] v;

        truth_tab[0] = 4'b0111; // NAND
        truth_tab[1] = 4'b1000; // AND
        truth_tab[2] = 4'b0001; // NOR
        truth_tab[3] = 4'b1110; // OR
        truth_tab[4] = 4'b0110; // XOR
        truth_tab[5] = 4'b1001; // XNOR
        truth_tab[6] = 4'b1100; // pass A
        truth_tab[7] = 4'b0011; // NOT A

        rst_n       = 1'b0;
        bus4.ena    = 1'b1;
        bus4.ui_in  = 8'h00;
        bus4.uio_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: no counts change
        repeat (10) step();
        check("idle_cnt", {4'h0, bus4.uo_out[7:4]}, 8'h00);

        // NAND with A0=B0=1: Y0 falls on the third edge, count reads 1
        bus4.ui_in = 8'h11;
        step();
        step();
        check("y0_hold", {7'b0, bus4.uo_out[0]}, 8'h01);
        step();
        check("y0_fall", {7'b0, bus4.uo_out[0]}, 8'h00);
        check("cnt0_one", {4'h0, bus4.uo_out[7:4]}, 8'h01);

        // Load XOR with a one-cycle strobe, A1=1 B1=0
        bus4.ui_in = 8'h02;
        repeat (4) step();
        bus4.uio_in = 8'h0C;
        step();
        bus4.uio_in = 8'h04;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus4.uio_out[6]) acks++;
        end
        check("xor_ack_once", 8'(acks), 8'd1);
        check("xor_cnt0_clear", {4'h0, bus4.uo_out[7:4]}, 8'h00);
        check("xor_y1", {7'b0, bus4.uo_out[1]}, 8'h01);

        // Pass A, toggle A2 twenty times: counter 2 saturates
        bus4.uio_in = 8'h2E;
        step();
        bus4.uio_in = 8'h26;
        repeat (4) step();
        for (int i = 0; i < 20; i++) begin
            v = 8'($urandom);
            v[2] = i[0];
            bus4.ui_in = v;
            step();
        end
        repeat (4) step();
        check("cnt2_sat", {4'h0, bus4.uo_out[7:4]}, 8'h0F);
        check("sat2_flag", {7'b0, bus4.uio_out[7]}, 8'h01);
        bus4.uio_in = 8'h36;
        repeat (3) step();

        // Strobe held high with a changing code: one load only
        acks = 0;
        for (int i = 0; i < 54; i++) begin
            bus4.uio_in = 8'(8 | $urandom_range(0, 7));
            bus4.ui_in  = 8'($urandom);
            step();
            if (bus4.uio_out[6]) acks++;
        end
        check("held_ack_once", 8'(acks), 8'd1);
        bus4.uio_in = 8'h03;
        repeat (4) step();
        acks = 0;
        bus4.uio_in = 8'h0B;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus4.uio_out[6]) acks++;
        end
        check("reraise_ack", 8'(acks), 8'd1);

        // Random traffic with occasional loads and all select values
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom);
            v[3] = ($urandom_range(0, 15) == 0);
            bus4.uio_in = v;
            bus4.ui_in  = 8'($urandom);
            step();
        end

        // OR mode, toggle A0 so counter 0 is nonzero, then reset mid-cycle
        bus4.uio_in = 8'h0B;
        step();
        bus4.uio_in = 8'h03;
        repeat (4) step();
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom);
            v[0] = i[0];
            v[4] = 1'b0;
            bus4.ui_in = v;
            step();
        end
        check("or_cnt_live", {7'b0, (bus4.uo_out[7:4] != 4'h0)}, 8'h01);
        bus4.ui_in = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus4.ui_in  = 8'($urandom);
            bus4.uio_in = 8'($urandom) & 8'hF7;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
